// File: rtl/phy_ctr_responder.sv
// Avalon-MM control-port responder: MAC control registers plus a 16-bit PHY window.
// Each access is stalled for a fixed number of wait states.
module phy_ctr_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RST_CYCLES  = 8,
    parameter logic [31:0] REV         = 32'h0000_0901,
    parameter logic [31:0] PHY_ID      = 32'h0022_1556
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [15:0] o_wr_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    logic [3:0]  wcnt;
    logic        stalled;
    logic [31:0] scratch;
    logic [31:0] cmd_cfg;
    logic [4:0]  mdio_addr0;
    logic [7:0]  cc_rst;
    logic [7:0]  phy_rst;
    logic [15:0] phy_regs [32];

    logic       req;
    logic       wr_done;
    logic       abort;
    logic       in_phy;
    logic [4:0] phy_idx;
    logic       cc_busy;
    logic       phy_busy;
    logic       phy_clr;

    assign req         = read | write;
    assign waitrequest = req & (wcnt < WAIT_LIM);
    assign wr_done     = write & ~waitrequest;
    assign abort       = stalled & ~req;
    assign in_phy      = (address[7:5] == 3'b100);
    assign phy_idx     = address[4:0];
    assign cc_busy     = (cc_rst != 8'd0);
    assign phy_busy    = (phy_rst != 8'd0);
    assign phy_clr     = (phy_rst == 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt       <= 4'd0;
            stalled    <= 1'b0;
            scratch    <= 32'd0;
            cmd_cfg    <= 32'd0;
            mdio_addr0 <= 5'd0;
            cc_rst     <= 8'd0;
            phy_rst    <= 8'd0;
            o_wr_cnt   <= 16'd0;
            o_err_cnt  <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                phy_regs[i] <= 16'd0;
            end
        end else begin
            wcnt    <= waitrequest ? wcnt + 4'd1 : 4'd0;
            stalled <= waitrequest;

            if (abort && o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
            if (wr_done && o_wr_cnt != 16'hFFFF) begin
                o_wr_cnt <= o_wr_cnt + 16'd1;
            end

            if (wr_done && address == 8'h01) begin
                scratch <= writedata;
            end
            // Bit 13 is never stored; it reads back from the countdown.
            if (wr_done && address == 8'h02) begin
                cmd_cfg <= {writedata[31:14], 1'b0, writedata[12:0]};
            end
            if (wr_done && address == 8'h0F) begin
                mdio_addr0 <= writedata[4:0];
            end

            if (wr_done && address == 8'h02 && writedata[13]) begin
                cc_rst <= RST_LOAD;
            end else if (cc_busy) begin
                cc_rst <= cc_rst - 8'd1;
            end

            if (wr_done && address == 8'h80 && writedata[15]) begin
                phy_rst <= RST_LOAD;
            end else if (phy_busy) begin
                phy_rst <= phy_rst - 8'd1;
            end

            // The end-of-reset clear takes priority over a coincident write.
            for (int i = 0; i < 32; i++) begin
                if (phy_clr && (i == 0 || i >= 4)) begin
                    phy_regs[i] <= 16'd0;
                end else if (wr_done && in_phy && phy_idx == 5'(i)) begin
                    if (i == 0) begin
                        phy_regs[i] <= {1'b0, writedata[14:0]};
                    end else if (i >= 4) begin
                        phy_regs[i] <= writedata[15:0];
                    end
                end
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (read && !write) begin
            if (in_phy) begin
                case (phy_idx)
                    5'd0:    readdata = {16'h0, phy_regs[0] | {phy_busy, 15'h0}};
                    5'd1:    readdata = 32'h0000_786D;
                    5'd2:    readdata = {16'h0, PHY_ID[31:16]};
                    5'd3:    readdata = {16'h0, PHY_ID[15:0]};
                    default: readdata = {16'h0, phy_regs[phy_idx]};
                endcase
            end else begin
                case (address)
                    8'h00:   readdata = REV;
                    8'h01:   readdata = scratch;
                    8'h02:   readdata = cmd_cfg | {18'h0, cc_busy, 13'h0};
                    8'h0F:   readdata = {27'h0, mdio_addr0};
                    default: readdata = 32'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phy_ctr_responder.sv
// Scoreboard bench for phy_ctr_responder: stimulus queues expected read data and
// stall counts, a negedge monitor checks each completed transfer.
module tb_phy_ctr_responder;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [15:0] o_wr_cnt;
    logic [7:0]  o_err_cnt;

    typedef struct {
        logic [31:0] data;
        int          stalls;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   fails = 0;
    int   stalls = 0;
    int   exp_wr = 0;

    phy_ctr_responder #(
        .WAIT_CYCLES(WAIT),
        .RST_CYCLES(8),
        .REV(32'h0000_0901),
        .PHY_ID(32'h0022_1556)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .writedata(writedata),
        .write(write),
        .read(read),
        .readdata(readdata),
        .waitrequest(waitrequest),
        .o_wr_cnt(o_wr_cnt),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: count stall cycles, check data and latency on completion
    always @(negedge clk) begin
        if (reset || !(read || write)) begin
            stalls = 0;
        end else if (waitrequest) begin
            stalls++;
        end else begin
            compared++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_completion: addr %h data %h, none queued",
                         address, readdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (readdata !== e.data || stalls != e.stalls) begin
                    fails++;
                    $display("FAIL %s: got data %h stalls %0d, want data %h stalls %0d",
                             e.name, readdata, stalls, e.data, e.stalls);
                end
            end
            stalls = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] exp,
                           input string name);
        int n;
        sb.push_back('{exp, WAIT, name});
        read = rd;
        write = wr;
        address = a;
        writedata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (waitrequest && n < 40);
        if (waitrequest) begin
            compared++;
            fails++;
            $display("FAIL %s_timeout: waitrequest %b after %0d cycles, want 0",
                     name, waitrequest, n);
        end
        @(posedge clk);
        #1;
        read = 1'b0;
        write = 1'b0;
        if (wr) exp_wr++;
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        address = 8'h00;
        writedata = 32'd0;

        #2;
        read = 1'b1;
        #1;
        check("reset_rd_rev", readdata, 32'h0000_0901);
        check("reset_wait_on_req", {31'd0, waitrequest}, 32'd1);
        read = 1'b0;
        #1;
        check("reset_wait_idle", {31'd0, waitrequest}, 32'd0);
        check("reset_wr_cnt", {16'd0, o_wr_cnt}, 32'd0);
        check("reset_err_cnt", {24'd0, o_err_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_xfer(1, 0, 8'h00, 0, 32'h0000_0901, "rd_rev");
        do_xfer(0, 1, 8'h01, 32'hDEAD_BEEF, 0, "wr_scratch");
        do_xfer(1, 0, 8'h01, 0, 32'hDEAD_BEEF, "rd_scratch");
        check("wr_cnt_1", {16'd0, o_wr_cnt}, 32'd1);

        do_xfer(0, 1, 8'h90, 32'h0000_1234, 0, "wr_0x90");
        do_xfer(1, 0, 8'h90, 0, 32'h0000_1234, "rd_0x90");

        // BMCR self-clearing reset: hold a read of 0x80 for 12 clocks
        do_xfer(0, 1, 8'h80, 32'h0000_8000, 0, "wr_bmcr");
        sb.push_back('{32'h0000_8000, WAIT, "bmcr_busy_a"});
        sb.push_back('{32'h0000_8000, WAIT, "bmcr_busy_b"});
        sb.push_back('{32'h0000_0000, WAIT, "bmcr_done_a"});
        sb.push_back('{32'h0000_0000, WAIT, "bmcr_done_b"});
        read = 1'b1;
        address = 8'h80;
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (readdata[15]) hi++;
        end
        @(posedge clk);
        #1;
        read = 1'b0;
        check("bmcr_bit15_clocks", 32'(hi), 32'd8);
        do_xfer(1, 0, 8'h90, 0, 32'h0000_0000, "rd_0x90_cleared");

        do_xfer(0, 1, 8'h82, 32'h0000_FFFF, 0, "wr_phyid_ro");
        do_xfer(1, 0, 8'h82, 0, 32'h0000_0022, "rd_phyid_hi");
        do_xfer(1, 0, 8'h83, 0, 32'h0000_1556, "rd_phyid_lo");
        do_xfer(1, 0, 8'h81, 0, 32'h0000_786D, "rd_bmsr");
        check("wr_cnt_4", {16'd0, o_wr_cnt}, 32'(exp_wr));

        // Aborted read after one stall cycle
        read = 1'b1;
        address = 8'h01;
        @(negedge clk);
        @(posedge clk);
        #1;
        read = 1'b0;
        @(posedge clk);
        #1;
        check("err_cnt_abort", {24'd0, o_err_cnt}, 32'd1);
        do_xfer(1, 0, 8'h01, 0, 32'hDEAD_BEEF, "rd_after_abort");

        do_xfer(1, 1, 8'h0F, 32'hFFFF_FFFF, 0, "rw_mdio");
        do_xfer(1, 0, 8'h0F, 0, 32'h0000_001F, "rd_mdio");

        do_xfer(0, 1, 8'h02, 32'h0000_2005, 0, "wr_cmd_cfg");
        do_xfer(1, 0, 8'h02, 0, 32'h0000_2005, "rd_cmd_cfg_busy");
        repeat (8) @(posedge clk);
        #1;
        do_xfer(1, 0, 8'h02, 0, 32'h0000_0005, "rd_cmd_cfg_done");

        do_xfer(0, 1, 8'h40, 32'h1111_2222, 0, "wr_unmapped");
        do_xfer(1, 0, 8'h40, 0, 32'h0000_0000, "rd_unmapped");
        do_xfer(0, 1, 8'h00, 32'h1234_5678, 0, "wr_rev_ro");
        do_xfer(1, 0, 8'h00, 0, 32'h0000_0901, "rd_rev_again");
        check("wr_cnt_final", {16'd0, o_wr_cnt}, 32'(exp_wr));
        check("err_cnt_final", {24'd0, o_err_cnt}, 32'd1);

        // Reset in the middle of a stalled write
        write = 1'b1;
        address = 8'h01;
        writedata = 32'h5555_AAAA;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("midrst_wr_cnt", {16'd0, o_wr_cnt}, 32'd0);
        check("midrst_err_cnt", {24'd0, o_err_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_xfer(1, 0, 8'h01, 0, 32'h0000_0000, "rd_scratch_after_rst");
        check("post_rst_err_cnt", {24'd0, o_err_cnt}, 32'd0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
